// File: rtl/rv32_pkg.sv
// Shared types for the RV32I memory port arbiter: FSM states, requester ids, access control bundle.
// Pure declarations; no timing or flow-control behaviour of its own.
package rv32_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  localparam int unsigned MEM_LAT_DEF = 2;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_ctl_t;

endpackage

// File: rtl/lat_counter.sv
// 4-bit loadable up-counter with a terminal-count flag comparing against i_term.
// Single-cycle load/increment; no backpressure, the owner decides when to count.
module lat_counter (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_en,
  input  logic [3:0] i_term,
  output logic       o_tc
);

  logic [3:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_tc = (r_cnt == i_term);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store; done = MEM_LAT+1 after grant cycle.
// Requesters hold req until done; halt freezes new grants but never aborts an in-flight access.
module mem_port_arbiter
  import rv32_pkg::*;
#(
  parameter int unsigned MEM_LAT = MEM_LAT_DEF,
  parameter int unsigned AW      = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_halt,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic [31:0]   o_if_rdata,
  output logic          o_if_done,
  input  logic          i_d_req,
  input  logic          i_d_we,
  input  logic [3:0]    i_d_be,
  input  logic [AW-1:0] i_d_addr,
  input  logic [31:0]   i_d_wdata,
  output logic [31:0]   o_d_rdata,
  output logic          o_d_done,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [3:0]    o_mem_be,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  input  logic [31:0]   i_mem_rdata,
  output logic          o_busy
);

  localparam logic [3:0] LAT_TERM = 4'(MEM_LAT - 1);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  logic          r_gnt;
  logic          r_last_gnt;
  logic [AW-1:0] r_addr;
  mem_ctl_t      r_ctl;
  logic [31:0]   r_if_rdata;
  logic [31:0]   r_d_rdata;

  logic          w_grant;
  logic          w_gnt_sel;
  logic          w_tc;
  logic          w_capture;
  logic          w_unused;

  // Byte lanes are chosen by the requester through d_be, so the low address bits are dropped.
  assign w_unused = ^{i_if_addr[1:0], i_d_addr[1:0]};

  lat_counter u_lat_counter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_grant),
    .i_load_val (4'd0),
    .i_en       (r_state == BUSY),
    .i_term     (LAT_TERM),
    .o_tc       (w_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_gnt_sel   = GNT_FETCH;
    case (r_state)
      IDLE: begin
        if (!i_halt && (i_if_req || i_d_req)) begin
          w_grant     = 1'b1;
          w_state_nxt = BUSY;
          if (i_if_req && i_d_req) begin
            w_gnt_sel = ~r_last_gnt;
          end else begin
            w_gnt_sel = i_d_req ? GNT_DATA : GNT_FETCH;
          end
        end
      end
      BUSY: begin
        if (w_tc) begin
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_capture = (r_state == BUSY) && w_tc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_gnt      <= GNT_FETCH;
      r_last_gnt <= GNT_FETCH;
      r_addr     <= '0;
      r_ctl      <= '0;
      r_if_rdata <= 32'd0;
      r_d_rdata  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_gnt <= w_gnt_sel;
        if (w_gnt_sel == GNT_DATA) begin
          r_addr <= {i_d_addr[AW-1:2], 2'b00};
          r_ctl  <= '{we: i_d_we, be: i_d_be, wdata: i_d_wdata};
        end else begin
          r_addr <= {i_if_addr[AW-1:2], 2'b00};
          r_ctl  <= '0;
        end
      end
      // Round-robin history only advances once an access actually completes.
      if (w_capture) begin
        r_last_gnt <= r_gnt;
        if (r_gnt == GNT_FETCH) begin
          r_if_rdata <= i_mem_rdata;
        end else if (!r_ctl.we) begin
          r_d_rdata <= i_mem_rdata;
        end
      end
    end
  end

  assign o_mem_en    = (r_state == BUSY);
  assign o_mem_we    = o_mem_en && r_ctl.we;
  assign o_mem_be    = r_ctl.be;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_ctl.wdata;
  assign o_busy      = (r_state != IDLE);
  assign o_if_done   = (r_state == RESP) && (r_gnt == GNT_FETCH);
  assign o_d_done    = (r_state == RESP) && (r_gnt == GNT_DATA);
  assign o_if_rdata  = r_if_rdata;
  assign o_d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios then randomized concurrent fetch/data traffic.
// A latency-accurate memory model feeds the DUT; expected rdata comes from a separate word-array model.
module tb_mem_port_arbiter;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_halt;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic [31:0] o_if_rdata;
  logic        o_if_done;
  logic        i_d_req;
  logic        i_d_we;
  logic [3:0]  i_d_be;
  logic [31:0] i_d_addr;
  logic [31:0] i_d_wdata;
  logic [31:0] o_d_rdata;
  logic        o_d_done;
  logic        o_mem_en;
  logic        o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata = 32'd0;
  logic        o_busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .AW(32)) dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_halt      (i_halt),
    .i_if_req    (i_if_req),
    .i_if_addr   (i_if_addr),
    .o_if_rdata  (o_if_rdata),
    .o_if_done   (o_if_done),
    .i_d_req     (i_d_req),
    .i_d_we      (i_d_we),
    .i_d_be      (i_d_be),
    .i_d_addr    (i_d_addr),
    .i_d_wdata   (i_d_wdata),
    .o_d_rdata   (o_d_rdata),
    .o_d_done    (o_d_done),
    .o_mem_en    (o_mem_en),
    .o_mem_we    (o_mem_we),
    .o_mem_be    (o_mem_be),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata),
    .o_busy      (o_busy)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  int          agents_done = 0;
  logic [31:0] ref_mem [256];
  logic [31:0] env_mem [256];
  logic [31:0] if_exp_q [$];
  logic [31:0] d_exp_q [$];
  logic [31:0] last_load = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Memory environment: data is only valid in the last latency cycle, garbage otherwise.
  int          env_cnt = 0;
  logic [31:0] env_first_addr = 32'd0;
  always @(negedge clk) begin
    if (o_mem_en) begin
      env_cnt++;
      if (env_cnt == 1) begin
        env_first_addr = o_mem_addr;
        check("mem_addr_aligned", {30'd0, o_mem_addr[1:0]}, 32'd0);
      end else begin
        check("mem_addr_stable", o_mem_addr, env_first_addr);
      end
      if (env_cnt == MEM_LAT) begin
        i_mem_rdata = env_mem[o_mem_addr[9:2]];
        if (o_mem_we) begin
          for (int b = 0; b < 4; b++) begin
            if (o_mem_be[b]) env_mem[o_mem_addr[9:2]][b*8 +: 8] = o_mem_wdata[b*8 +: 8];
          end
        end
      end else begin
        i_mem_rdata = $urandom;
      end
    end else begin
      env_cnt = 0;
      i_mem_rdata = $urandom;
      check("mem_we_gated", {31'd0, o_mem_we}, 32'd0);
    end
  end

  // Scoreboard monitor: every done pops one expectation for that requester.
  logic prev_if_done = 1'b0;
  logic prev_d_done  = 1'b0;
  always @(negedge clk) begin
    if (o_if_done) begin
      check("if_done_single", {31'd0, prev_if_done}, 32'd0);
      if (if_exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL if_done_unexpected: actual=done expected=no done");
      end else begin
        check("if_rdata", o_if_rdata, if_exp_q.pop_front());
      end
    end
    if (o_d_done) begin
      check("d_done_single", {31'd0, prev_d_done}, 32'd0);
      if (d_exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL d_done_unexpected: actual=done expected=no done");
      end else begin
        check("d_rdata", o_d_rdata, d_exp_q.pop_front());
      end
    end
    prev_if_done = o_if_done;
    prev_d_done  = o_d_done;
  end

  task automatic issue_fetch(input logic [31:0] a);
    if_exp_q.push_back(ref_mem[a[9:2]]);
    i_if_addr = a;
    i_if_req  = 1'b1;
  endtask

  task automatic issue_data(input logic we, input logic [3:0] be, input logic [31:0] a,
                            input logic [31:0] wd);
    logic [7:0] idx;
    idx = a[9:2];
    if (!we) begin
      last_load = ref_mem[idx];
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ref_mem[idx][b*8 +: 8] = wd[b*8 +: 8];
      end
    end
    d_exp_q.push_back(last_load);
    i_d_we    = we;
    i_d_be    = be;
    i_d_addr  = a;
    i_d_wdata = wd;
    i_d_req   = 1'b1;
  endtask

  task automatic wait_done(input bit is_data, input string name, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (cyc < 100 && !seen) begin
      tick();
      cyc++;
      seen = is_data ? o_d_done : o_if_done;
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: actual=no done after %0d cycles expected=done", name, cyc);
    end
    if (is_data) i_d_req = 1'b0;
    else         i_if_req = 1'b0;
  endtask

  task automatic do_reset(input int n);
    i_rst_n  = 1'b0;
    i_if_req = 1'b0;
    i_d_req  = 1'b0;
    repeat (n) tick();
    if_exp_q.delete();
    d_exp_q.delete();
    last_load = 32'd0;
    i_rst_n = 1'b1;
  endtask

  task automatic fetch_agent();
    int c;
    repeat (40) begin
      repeat ($urandom_range(0, 4)) tick();
      issue_fetch({22'd0, 1'b0, 7'($urandom), 2'b00});
      wait_done(1'b0, "rnd_fetch", c);
    end
    agents_done++;
  endtask

  task automatic data_agent();
    int c;
    repeat (40) begin
      repeat ($urandom_range(0, 4)) tick();
      issue_data(1'($urandom), 4'($urandom), {22'd0, 1'b1, 7'($urandom), 2'($urandom)}, $urandom);
      wait_done(1'b1, "rnd_data", c);
    end
    agents_done++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=simulation still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    i_rst_n   = 1'b0;
    i_halt    = 1'b0;
    i_if_req  = 1'b1;
    i_if_addr = 32'h0000_0104;
    i_d_req   = 1'b0;
    i_d_we    = 1'b0;
    i_d_be    = 4'h0;
    i_d_addr  = 32'd0;
    i_d_wdata = 32'd0;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    env_mem[8'h41] = 32'h0000_0513;
    ref_mem[8'h41] = 32'h0000_0513;

    // Reset held with a pending fetch, then release into a fetch-only access.
    repeat (3) begin
      tick();
      check("rst_outputs_zero",
            {31'd0, |{o_if_rdata, o_d_rdata, o_if_done, o_d_done, o_mem_en, o_mem_we,
                      o_mem_be, o_mem_addr, o_mem_wdata, o_busy}}, 32'd0);
    end
    i_rst_n = 1'b1;
    issue_fetch(32'h0000_0104);
    tick();
    check("rel_mem_en", {31'd0, o_mem_en}, 32'd1);
    check("fetch_mem_addr", o_mem_addr, 32'h0000_0104);
    check("fetch_mem_we", {31'd0, o_mem_we}, 32'd0);
    wait_done(1'b0, "t1_fetch", cyc);
    check("fetch_done_latency", 32'(cyc + 1), 32'd3);
    check("fetch_if_rdata", o_if_rdata, 32'h0000_0513);
    tick();
    check("fetch_done_dropped", {31'd0, o_if_done}, 32'd0);

    // Store with misaligned address, then read it back.
    issue_data(1'b1, 4'b0011, 32'h0000_0203, 32'hDEAD_BEEF);
    tick();
    check("store_mem_addr", o_mem_addr, 32'h0000_0200);
    check("store_mem_be", {28'd0, o_mem_be}, 32'h3);
    check("store_mem_wdata", o_mem_wdata, 32'hDEAD_BEEF);
    check("store_mem_we", {31'd0, o_mem_we}, 32'd1);
    wait_done(1'b1, "t3_store", cyc);
    check("store_d_rdata_kept", o_d_rdata, 32'd0);
    tick();
    issue_data(1'b0, 4'hF, 32'h0000_0200, 32'd0);
    wait_done(1'b1, "t3_load", cyc);

    // Ties after reset: data, fetch, data, fetch.
    tick();
    do_reset(2);
    for (int r = 0; r < 2; r++) begin
      if (r == 1) tick();
      issue_fetch(32'h0000_0010 + 32'(r * 16));
      issue_data(1'b0, 4'hF, 32'h0000_0300 + 32'(r * 16), 32'd0);
      tick();
      check("tie_data_first", o_mem_addr, 32'h0000_0300 + 32'(r * 16));
      wait_done(1'b1, "t4_data", cyc);
      tick();
      tick();
      check("tie_then_fetch", o_mem_addr, 32'h0000_0010 + 32'(r * 16));
      wait_done(1'b0, "t4_fetch", cyc);
    end

    // Halt in the 2nd busy cycle: in-flight fetch completes, then grants freeze.
    tick();
    issue_fetch(32'h0000_0040);
    tick();
    tick();
    i_halt = 1'b1;
    wait_done(1'b0, "t5_fetch", cyc);
    check("halt_inflight_done", 32'(cyc), 32'd1);
    tick();
    issue_fetch(32'h0000_0044);
    repeat (10) begin
      tick();
      check("halt_mem_en", {31'd0, o_mem_en}, 32'd0);
    end
    i_halt = 1'b0;
    wait_done(1'b0, "t5_resume", cyc);

    // Reset in the middle of a busy access: no done, port released at once.
    tick();
    issue_fetch(32'h0000_0080);
    tick();
    i_rst_n  = 1'b0;
    i_if_req = 1'b0;
    if_exp_q.delete();
    tick();
    check("midrst_mem_en", {31'd0, o_mem_en}, 32'd0);
    check("midrst_busy", {31'd0, o_busy}, 32'd0);
    check("midrst_no_done", {31'd0, o_if_done | o_d_done}, 32'd0);
    tick();
    check("midrst_no_done2", {31'd0, o_if_done | o_d_done}, 32'd0);
    last_load = 32'd0;
    i_rst_n = 1'b1;
    tick();

    // Randomized concurrent traffic with sporadic halts.
    fork
      fetch_agent();
      data_agent();
      begin
        while (agents_done < 2) begin
          tick();
          i_halt = ($urandom_range(0, 7) == 0);
        end
        i_halt = 1'b0;
      end
    join

    repeat (4) tick();
    check("if_queue_drained", 32'(if_exp_q.size()), 32'd0);
    check("d_queue_drained", 32'(d_exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
